// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS sequencer: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB and drives datapath strobes and select codes.
module multicycle_ctrl #(
    parameter int CODE_W   = 8,
    parameter int MEM_WAIT = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        op,
    input  logic [5:0]        funct,
    input  logic              is_eq,
    output logic              ir_we,
    output logic              pc_we,
    output logic              reg_write,
    output logic              mem_write,
    output logic [CODE_W-1:0] npc_op,
    output logic [CODE_W-1:0] reg_dst,
    output logic [CODE_W-1:0] reg_src,
    output logic [CODE_W-1:0] ext_op,
    output logic [CODE_W-1:0] alu_op,
    output logic [CODE_W-1:0] alu_src,
    output logic [2:0]        state,
    output logic              illegal
);

    localparam int CNT_W = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        I_ADDU, I_SUBU, I_ORI, I_LUI, I_LW,
        I_SW, I_BEQ, I_JAL, I_JR, I_NOP
    } cls_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              illegal_q, illegal_d;

    cls_t              cls;
    logic              bad;
    logic [CODE_W-1:0] dec_npc, dec_dst, dec_src;
    logic [CODE_W-1:0] dec_ext, dec_alu, dec_asrc;

    logic              ir_we_c, pc_we_c, reg_write_c, mem_write_c;
    logic              codes_en;

    // Classify op/funct; unsupported encodings run as nop and flag bad.
    always_comb begin
        cls = I_NOP;
        bad = 1'b0;
        case (op)
            6'h00: begin
                case (funct)
                    6'h21:   cls = I_ADDU;
                    6'h23:   cls = I_SUBU;
                    6'h08:   cls = I_JR;
                    6'h00:   cls = I_NOP;
                    default: bad = 1'b1;
                endcase
            end
            6'h0D:   cls = I_ORI;
            6'h0F:   cls = I_LUI;
            6'h23:   cls = I_LW;
            6'h2B:   cls = I_SW;
            6'h04:   cls = I_BEQ;
            6'h03:   cls = I_JAL;
            default: bad = 1'b1;
        endcase
    end

    // Select codes for the decoded class, held for the whole instruction.
    always_comb begin
        dec_npc  = '0;
        dec_dst  = '0;
        dec_src  = '0;
        dec_ext  = '0;
        dec_alu  = '0;
        dec_asrc = '0;
        case (cls)
            I_ADDU: begin
                dec_dst = CODE_W'(1);
            end
            I_SUBU: begin
                dec_dst = CODE_W'(1);
                dec_alu = CODE_W'(1);
            end
            I_ORI: begin
                dec_alu  = CODE_W'(2);
                dec_asrc = CODE_W'(1);
            end
            I_LUI: begin
                dec_ext = CODE_W'(2);
                dec_src = CODE_W'(2);
            end
            I_LW: begin
                dec_ext  = CODE_W'(1);
                dec_asrc = CODE_W'(1);
                dec_src  = CODE_W'(1);
            end
            I_SW: begin
                dec_ext  = CODE_W'(1);
                dec_asrc = CODE_W'(1);
            end
            I_BEQ: begin
                dec_alu = CODE_W'(1);
                dec_ext = CODE_W'(1);
                dec_npc = is_eq ? CODE_W'(1) : CODE_W'(0);
            end
            I_JAL: begin
                dec_dst = CODE_W'(2);
                dec_src = CODE_W'(3);
                dec_npc = CODE_W'(2);
            end
            I_JR: begin
                dec_npc = CODE_W'(3);
            end
            default: begin
                dec_npc = '0;
            end
        endcase
    end

    // Next state, MEM wait counter, sticky illegal and raw strobes.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        illegal_d   = illegal_q;
        ir_we_c     = 1'b0;
        pc_we_c     = 1'b0;
        reg_write_c = 1'b0;
        mem_write_c = 1'b0;
        codes_en    = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_we_c = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                codes_en = 1'b1;
                if (bad) illegal_d = 1'b1;
                case (cls)
                    I_JR, I_NOP: begin
                        pc_we_c = 1'b1;
                        state_d = S_FETCH;
                    end
                    I_JAL:   state_d = S_WB;
                    default: state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                codes_en = 1'b1;
                case (cls)
                    I_BEQ: begin
                        pc_we_c = 1'b1;
                        state_d = S_FETCH;
                    end
                    I_LW, I_SW: begin
                        cnt_d   = CNT_W'(MEM_WAIT);
                        state_d = S_MEM;
                    end
                    default: state_d = S_WB;
                endcase
            end
            S_MEM: begin
                codes_en = 1'b1;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (cls == I_SW) begin
                    mem_write_c = 1'b1;
                    pc_we_c     = 1'b1;
                    state_d     = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                codes_en    = 1'b1;
                reg_write_c = 1'b1;
                pc_we_c     = 1'b1;
                state_d     = S_FETCH;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_FETCH;
            end
        endcase
    end

    // State, counter and illegal flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
        end
    end

    assign ir_we     = ir_we_c & ~reset;
    assign pc_we     = pc_we_c & ~reset;
    assign reg_write = reg_write_c & ~reset;
    assign mem_write = mem_write_c & ~reset;

    assign npc_op  = codes_en ? dec_npc  : '0;
    assign reg_dst = codes_en ? dec_dst  : '0;
    assign reg_src = codes_en ? dec_src  : '0;
    assign ext_op  = codes_en ? dec_ext  : '0;
    assign alu_op  = codes_en ? dec_alu  : '0;
    assign alu_src = codes_en ? dec_asrc : '0;

    assign state   = state_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl (MEM_WAIT=2): stimulus queues
// per-cycle expected outputs, a negedge monitor pops and compares them.
module tb_multicycle_ctrl;

    localparam int MW = 2;

    typedef struct packed {
        logic [2:0] st;
        logic       ir;
        logic       pc;
        logic       rw;
        logic       mw;
        logic       ill;
        logic [7:0] npc;
        logic [7:0] dst;
        logic [7:0] src;
        logic [7:0] ext;
        logic [7:0] alu;
        logic [7:0] asrc;
    } obs_t;

    localparam int P_R   = 0;
    localparam int P_LW  = 1;
    localparam int P_SW  = 2;
    localparam int P_BEQ = 3;
    localparam int P_JAL = 4;
    localparam int P_NOP = 5;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       is_eq;
    logic       ir_we, pc_we, reg_write, mem_write;
    logic [7:0] npc_op, reg_dst, reg_src, ext_op, alu_op, alu_src;
    logic [2:0] state;
    logic       illegal;

    obs_t  sb[$];
    string nm[$];
    int    tests;
    int    failed;
    logic  ill;

    multicycle_ctrl #(.CODE_W(8), .MEM_WAIT(MW)) dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .funct     (funct),
        .is_eq     (is_eq),
        .ir_we     (ir_we),
        .pc_we     (pc_we),
        .reg_write (reg_write),
        .mem_write (mem_write),
        .npc_op    (npc_op),
        .reg_dst   (reg_dst),
        .reg_src   (reg_src),
        .ext_op    (ext_op),
        .alu_op    (alu_op),
        .alu_src   (alu_src),
        .state     (state),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every out-of-reset cycle is one presented output.
    always @(negedge clk) begin
        obs_t  got;
        obs_t  exp;
        string n;
        if (!reset) begin
            got = '{state, ir_we, pc_we, reg_write, mem_write, illegal,
                    npc_op, reg_dst, reg_src, ext_op, alu_op, alu_src};
            tests++;
            if (sb.size() == 0) begin
                failed++;
                $display("FAIL underflow: got %h, no expected entry", got);
            end else begin
                exp = sb.pop_front();
                n   = nm.pop_front();
                if (got !== exp) begin
                    failed++;
                    $display("FAIL %s st%0d: got %h required %h",
                             n, exp.st, got, exp);
                end
            end
        end
    end

    task automatic run_instr(
        input string    name,
        input logic [5:0] op_i,
        input logic [5:0] funct_i,
        input logic     eq_i,
        input int       path,
        input logic [7:0] c_npc,
        input logic [7:0] c_dst,
        input logic [7:0] c_src,
        input logic [7:0] c_ext,
        input logic [7:0] c_alu,
        input logic [7:0] c_asrc,
        input logic     ill_after,
        input int       cut
    );
        logic [2:0] seq[$];
        int         n;
        obs_t       v;
        logic       last;
        seq.push_back(3'd0);
        seq.push_back(3'd1);
        if (path == P_R || path == P_LW || path == P_SW || path == P_BEQ)
            seq.push_back(3'd2);
        if (path == P_LW || path == P_SW)
            for (int i = 0; i <= MW; i++) seq.push_back(3'd3);
        if (path == P_R || path == P_LW || path == P_JAL)
            seq.push_back(3'd4);
        n = (cut > 0) ? cut : seq.size();
        op    = op_i;
        funct = funct_i;
        is_eq = eq_i;
        for (int i = 0; i < n; i++) begin
            last = (i == seq.size() - 1);
            v = '0;
            v.st  = seq[i];
            v.ill = ill;
            if (i == 0) begin
                v.ir = 1'b1;
            end else begin
                v.pc   = last;
                v.rw   = (seq[i] == 3'd4);
                v.mw   = (path == P_SW) && last;
                v.npc  = c_npc;
                v.dst  = c_dst;
                v.src  = c_src;
                v.ext  = c_ext;
                v.alu  = c_alu;
                v.asrc = c_asrc;
            end
            sb.push_back(v);
            nm.push_back(name);
            if (i == 1 && ill_after) ill = 1'b1;
        end
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] got,
                       input logic [7:0] req);
        tests++;
        if (got !== req) begin
            failed++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end
    endtask

    task automatic check_reset_state();
        chk("rst_state", {5'd0, state}, 8'd0);
        chk("rst_strobes", {4'd0, ir_we, pc_we, reg_write, mem_write}, 8'd0);
        chk("rst_illegal", {7'd0, illegal}, 8'd0);
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        ill    = 1'b0;
        reset  = 1'b1;
        op     = '0;
        funct  = '0;
        is_eq  = 1'b0;
        #1;
        check_reset_state();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        //          name    op     funct  eq  path   npc dst src ext alu asrc ill cut
        run_instr("addu", 6'h00, 6'h21, 0, P_R,   0, 1, 0, 0, 0, 0, 0, 0);
        run_instr("subu", 6'h00, 6'h23, 0, P_R,   0, 1, 0, 0, 1, 0, 0, 0);
        run_instr("ori",  6'h0D, 6'h00, 0, P_R,   0, 0, 0, 0, 2, 1, 0, 0);
        run_instr("lui",  6'h0F, 6'h00, 0, P_R,   0, 0, 2, 2, 0, 0, 0, 0);
        run_instr("lw",   6'h23, 6'h00, 0, P_LW,  0, 0, 1, 1, 0, 1, 0, 0);
        run_instr("sw",   6'h2B, 6'h00, 0, P_SW,  0, 0, 0, 1, 0, 1, 0, 0);
        run_instr("beq1", 6'h04, 6'h00, 1, P_BEQ, 1, 0, 0, 1, 1, 0, 0, 0);
        run_instr("beq0", 6'h04, 6'h00, 0, P_BEQ, 0, 0, 0, 1, 1, 0, 0, 0);
        run_instr("jr",   6'h00, 6'h08, 0, P_NOP, 3, 0, 0, 0, 0, 0, 0, 0);
        run_instr("nop",  6'h00, 6'h00, 0, P_NOP, 0, 0, 0, 0, 0, 0, 0, 0);
        run_instr("jal",  6'h03, 6'h00, 0, P_JAL, 2, 2, 3, 0, 0, 0, 0, 0);
        run_instr("bad3f",6'h3F, 6'h00, 0, P_NOP, 0, 0, 0, 0, 0, 0, 1, 0);
        run_instr("addu2",6'h00, 6'h21, 0, P_R,   0, 1, 0, 0, 0, 0, 0, 0);
        run_instr("nop2", 6'h00, 6'h00, 0, P_NOP, 0, 0, 0, 0, 0, 0, 0, 0);

        // lw cut after its first MEM cycle; reset lands in the second
        run_instr("lwcut",6'h23, 6'h00, 0, P_LW,  0, 0, 1, 1, 0, 1, 0, 4);
        chk("pre_rst_state", {5'd0, state}, 8'd3);
        reset = 1'b1;
        ill   = 1'b0;
        #1;
        check_reset_state();
        @(posedge clk);
        #1;
        reset = 1'b0;

        run_instr("lw2",  6'h23, 6'h00, 0, P_LW,  0, 0, 1, 1, 0, 1, 0, 0);
        run_instr("badfn",6'h00, 6'h22, 0, P_NOP, 0, 0, 0, 0, 0, 0, 1, 0);
        run_instr("sw2",  6'h2B, 6'h00, 0, P_SW,  0, 0, 0, 1, 0, 1, 0, 0);

        reset = 1'b1;
        #1;
        check_reset_state();
        #20;
        tests++;
        if (sb.size() != 0) begin
            failed++;
            $display("FAIL drain: got %0d entries left required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
